store_mem_controller: RTL and testbench

Memory-side controller that consumes the address and data channels produced by a store port and commits them as single-cycle writes on a BRAM-style write interface. It pairs independently arriving address and data tokens, tracks outstanding stores against per-block store counts on a control channel, and signals completion once all expected stores are committed. It sits directly downstream of the store port, between the dataflow circuit and on-chip memory.

---
 rtl/store_mem_controller_pkg.sv | 25 ++
 rtl/store_mem_controller_fifo.sv | 70 +++++++
 rtl/store_mem_controller.sv | 167 ++++++++++++++++
 tb/tb_store_mem_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_mem_controller_pkg.sv
// Shared definitions for the store memory controller: FSM encoding and a
// pointer-width helper used by the pairing FIFOs.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } mc_state_e;

    // Ceiling log2, used to size FIFO read/write pointers.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/store_mem_controller_fifo.sv
// Synchronous FIFO holding one side (address or data) of pending stores.
// Full/empty derive only from registered pointers with an extra wrap bit.
module mc_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = clog2_f(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/store_mem_controller.sv
// Pairs store addresses with store data in arrival order, commits them as
// single-cycle BRAM writes, and signals completion once all counted stores land.
module store_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_TYPE  = 32,
    parameter int ADDR_TYPE  = 32,
    parameter int CTRL_TYPE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTRL_TYPE-1:0] ctrl,
    input  logic                 ctrl_valid,
    output logic                 ctrl_ready,
    input  logic                 ctrlEnd_valid,
    output logic                 ctrlEnd_ready,
    input  logic [ADDR_TYPE-1:0] addrIn,
    input  logic                 addrIn_valid,
    output logic                 addrIn_ready,
    input  logic [DATA_TYPE-1:0] dataIn,
    input  logic                 dataIn_valid,
    output logic                 dataIn_ready,
    output logic                 storeEn,
    output logic [ADDR_TYPE-1:0] storeAddr,
    output logic [DATA_TYPE-1:0] storeData,
    output logic                 memEnd_valid,
    input  logic                 memEnd_ready
);

    localparam logic signed [CTRL_TYPE:0] CNT_ONE = {{CTRL_TYPE{1'b0}}, 1'b1};

    mc_state_e              state_q;
    mc_state_e              state_d;
    logic signed [CTRL_TYPE:0] cnt_q;
    logic signed [CTRL_TYPE:0] cnt_d;
    logic                   store_en_q;
    logic                   store_en_d;
    logic [ADDR_TYPE-1:0]   store_addr_q;
    logic [ADDR_TYPE-1:0]   store_addr_d;
    logic [DATA_TYPE-1:0]   store_data_q;
    logic [DATA_TYPE-1:0]   store_data_d;
    logic                   mem_end_valid_q;
    logic                   mem_end_valid_d;

    logic                   addr_full_s;
    logic                   addr_empty_s;
    logic [ADDR_TYPE-1:0]   addr_head_s;
    logic                   data_full_s;
    logic                   data_empty_s;
    logic [DATA_TYPE-1:0]   data_head_s;
    logic                   commit_s;
    logic                   ctrl_fire_s;

    assign addrIn_ready  = !addr_full_s;
    assign dataIn_ready  = !data_full_s;
    assign ctrl_ready    = (state_q != ST_DONE);
    assign ctrlEnd_ready = (state_q == ST_RUN);
    assign storeEn       = store_en_q;
    assign storeAddr     = store_addr_q;
    assign storeData     = store_data_q;
    assign memEnd_valid  = mem_end_valid_q;

    assign commit_s    = !addr_empty_s && !data_empty_s;
    assign ctrl_fire_s = ctrl_valid && ctrl_ready;

    mc_fifo #(.WIDTH(ADDR_TYPE), .DEPTH(FIFO_DEPTH)) u_addr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (addrIn_valid),
        .push_data_i (addrIn),
        .pop_i       (commit_s),
        .full_o      (addr_full_s),
        .empty_o     (addr_empty_s),
        .head_o      (addr_head_s)
    );

    mc_fifo #(.WIDTH(DATA_TYPE), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (dataIn_valid),
        .push_data_i (dataIn),
        .pop_i       (commit_s),
        .full_o      (data_full_s),
        .empty_o     (data_empty_s),
        .head_o      (data_head_s)
    );

    // Write port and pending-store count; count may go negative when stores
    // arrive ahead of their block's ctrl token.
    always_comb begin
        store_en_d   = commit_s;
        store_addr_d = store_addr_q;
        store_data_d = store_data_q;
        cnt_d        = cnt_q;
        if (commit_s) begin
            store_addr_d = addr_head_s;
            store_data_d = data_head_s;
        end else begin
            store_addr_d = store_addr_q;
            store_data_d = store_data_q;
        end
        if (ctrl_fire_s) begin
            cnt_d = cnt_d + $signed({1'b0, ctrl});
        end else begin
            cnt_d = cnt_d;
        end
        if (commit_s) begin
            cnt_d = cnt_d - CNT_ONE;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Completion FSM; the drain check uses the updated count so a ctrl token
    // arriving alongside ctrlEnd is already included.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ctrlEnd_valid) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((cnt_d == '0) && addr_empty_s && data_empty_s && !commit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (memEnd_ready) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        mem_end_valid_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            cnt_q           <= '0;
            store_en_q      <= 1'b0;
            store_addr_q    <= '0;
            store_data_q    <= '0;
            mem_end_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            store_en_q      <= store_en_d;
            store_addr_q    <= store_addr_d;
            store_data_q    <= store_data_d;
            mem_end_valid_q <= mem_end_valid_d;
        end
    end

endmodule

// File: tb/tb_store_mem_controller.sv
// Directed bench for store_mem_controller: model queues of expected addresses
// and data are popped by a write monitor and compared against each storeEn.
module tb_store_mem_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        ctrlEnd_valid;
    logic        ctrlEnd_ready;
    logic [31:0] addrIn;
    logic        addrIn_valid;
    logic        addrIn_ready;
    logic [31:0] dataIn;
    logic        dataIn_valid;
    logic        dataIn_ready;
    logic        storeEn;
    logic [31:0] storeAddr;
    logic [31:0] storeData;
    logic        memEnd_valid;
    logic        memEnd_ready;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int cyc;
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    store_mem_controller #(
        .DATA_TYPE(32), .ADDR_TYPE(32), .CTRL_TYPE(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl(ctrl), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .ctrlEnd_valid(ctrlEnd_valid), .ctrlEnd_ready(ctrlEnd_ready),
        .addrIn(addrIn), .addrIn_valid(addrIn_valid), .addrIn_ready(addrIn_ready),
        .dataIn(dataIn), .dataIn_valid(dataIn_valid), .dataIn_ready(dataIn_ready),
        .storeEn(storeEn), .storeAddr(storeAddr), .storeData(storeData),
        .memEnd_valid(memEnd_valid), .memEnd_ready(memEnd_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctrl_valid    = 1'b0;
        ctrlEnd_valid = 1'b0;
        addrIn_valid  = 1'b0;
        dataIn_valid  = 1'b0;
    endtask

    task automatic pair(input logic [31:0] a, input logic [31:0] d);
        addrIn = a; addrIn_valid = 1'b1; exp_a.push_back(a);
        dataIn = d; dataIn_valid = 1'b1; exp_d.push_back(d);
    endtask

    task automatic wait_memend(input int budget, output int n);
        n = 0;
        while (!memEnd_valid && n < budget) begin
            step();
            n++;
        end
        chk("memEnd_within_budget", memEnd_valid, 1'b1);
    endtask

    task automatic end_handshake();
        memEnd_ready = 1'b1;
        step();
        memEnd_ready = 1'b0;
        chk("memEnd_drop", memEnd_valid, 1'b0);
        chk("back_to_run", ctrlEnd_ready, 1'b1);
    endtask

    // Write monitor: every committed store must match the next model pair.
    always @(negedge clk) begin
        if (storeEn === 1'b1) begin
            wr_count++;
            if (exp_a.size() == 0 || exp_d.size() == 0) begin
                chk("write_without_pair", storeEn, 1'b0);
            end else begin
                chk("store_addr", storeAddr, exp_a.pop_front());
                chk("store_data", storeData, exp_d.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; memEnd_ready = 1'b0;
        ctrl = '0; addrIn = '0; dataIn = '0;
        idle();
        step(); step();
        rst = 1'b0;
        chk("rst_addr_ready", addrIn_ready, 1'b1);
        chk("rst_data_ready", dataIn_ready, 1'b1);
        chk("rst_ctrl_ready", ctrl_ready, 1'b1);
        chk("rst_ctrlEnd_ready", ctrlEnd_ready, 1'b1);
        chk("rst_memEnd_valid", memEnd_valid, 1'b0);
        chk("rst_storeEn", storeEn, 1'b0);
        chk("rst_storeAddr", storeAddr, 32'h0);
        chk("rst_storeData", storeData, 32'h0);

        // Basic write: everything in one cycle.
        ctrl = 32'd1; ctrl_valid = 1'b1; ctrlEnd_valid = 1'b1;
        pair(32'h10, 32'hAB);
        step(); idle();
        chk("basic_latency_not_yet", storeEn, 1'b0);
        chk("basic_drain_ctrlEnd_ready", ctrlEnd_ready, 1'b0);
        step();
        chk("basic_storeEn", storeEn, 1'b1);
        chk("basic_no_early_memEnd", memEnd_valid, 1'b0);
        step();
        chk("basic_memEnd", memEnd_valid, 1'b1);
        chk("basic_done_ctrl_ready", ctrl_ready, 1'b0);
        end_handshake();
        chk("basic_wr_count", wr_count, 1);

        // Skewed arrival: addresses first, data five cycles later.
        for (int i = 0; i < 4; i++) begin
            addrIn = 32'(i); addrIn_valid = 1'b1; exp_a.push_back(32'(i));
            ctrl = 32'd4; ctrl_valid = (i == 0);
            step();
        end
        idle();
        chk("skew_addr_full", addrIn_ready, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("skew_no_write_yet", storeEn, 1'b0);
        chk("skew_no_memEnd_run", memEnd_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dataIn = 32'hA0 + 32'(i); dataIn_valid = 1'b1; exp_d.push_back(32'hA0 + 32'(i));
            step();
            if (i > 0) chk("skew_pulse", storeEn, 1'b1);
            if (i == 1) chk("skew_addr_ready_back", addrIn_ready, 1'b1);
        end
        idle();
        step();
        chk("skew_last_pulse", storeEn, 1'b1);
        step();
        chk("skew_pulses_end", storeEn, 1'b0);
        chk("skew_wr_count", wr_count, 5);
        ctrlEnd_valid = 1'b1;
        step(); idle();
        wait_memend(8, cyc);
        chk("skew_drain_latency", cyc, 1);
        end_handshake();

        // Stores committed before their ctrl count arrives.
        pair(32'h20, 32'h55); step();
        pair(32'h21, 32'h66); step();
        idle();
        step(); step(); step();
        chk("neg_wr_count", wr_count, 7);
        chk("neg_no_memEnd_run", memEnd_valid, 1'b0);
        chk("neg_still_run", ctrlEnd_ready, 1'b1);
        ctrl = 32'd2; ctrl_valid = 1'b1; ctrlEnd_valid = 1'b1;
        step(); idle();
        wait_memend(8, cyc);
        chk("neg_done_latency", cyc, 1);
        end_handshake();

        // ctrl=3 with a commit and ctrlEnd in the same cycle: net +2 pending.
        pair(32'h30, 32'h70); step(); idle();
        ctrl = 32'd3; ctrl_valid = 1'b1; ctrlEnd_valid = 1'b1;
        step(); idle();
        chk("sim_commit", storeEn, 1'b1);
        chk("sim_drain", ctrlEnd_ready, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("sim_waiting_two", memEnd_valid, 1'b0);
        pair(32'h31, 32'h71); step();
        pair(32'h32, 32'h72); step();
        idle();
        wait_memend(8, cyc);
        chk("sim_done_latency", cyc, 2);
        chk("sim_wr_count", wr_count, 10);
        end_handshake();

        // memEnd backpressure, then a second block.
        ctrl = 32'd1; ctrl_valid = 1'b1; ctrlEnd_valid = 1'b1;
        pair(32'h40, 32'hC4);
        step(); idle();
        wait_memend(8, cyc);
        chk("bp_done_latency", cyc, 2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_memEnd_hold", memEnd_valid, 1'b1);
            chk("bp_ctrl_ready_low", ctrl_ready, 1'b0);
        end
        end_handshake();
        chk("bp_ctrl_ready_back", ctrl_ready, 1'b1);
        ctrl = 32'd2; ctrl_valid = 1'b1;
        pair(32'h50, 32'hD0); step();
        ctrl_valid = 1'b0;
        pair(32'h51, 32'hD1); step();
        idle();
        ctrlEnd_valid = 1'b1;
        step(); idle();
        wait_memend(8, cyc);
        chk("bp2_done_latency", cyc, 1);
        chk("bp2_wr_count", wr_count, 13);
        end_handshake();

        // Reset with three buffered addresses and a count of five.
        ctrl = 32'd5; ctrl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addrIn = 32'h60 + 32'(i); addrIn_valid = 1'b1;
            step();
            ctrl_valid = 1'b0;
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_a.delete();
        exp_d.delete();
        chk("mid_rst_addr_ready", addrIn_ready, 1'b1);
        chk("mid_rst_data_ready", dataIn_ready, 1'b1);
        chk("mid_rst_ctrl_ready", ctrl_ready, 1'b1);
        chk("mid_rst_ctrlEnd_ready", ctrlEnd_ready, 1'b1);
        chk("mid_rst_memEnd", memEnd_valid, 1'b0);
        chk("mid_rst_storeEn", storeEn, 1'b0);
        dataIn = 32'h99; dataIn_valid = 1'b1; exp_d.push_back(32'h99);
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_no_write", storeEn, 1'b0);
        end
        chk("mid_rst_wr_count", wr_count, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
